// File: rtl/decode_issue_ctrl_pkg.sv
// Shared definitions for the decode-stage issue controller: RV32 opcode values,
// immediate-format select encoding, issue FSM states and the opcode classifier.
package decode_issue_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Width of one scoreboard countdown entry
    localparam int CNT_W = 2;

    typedef enum logic [3:0] {
        IMM_I = 4'd0,
        IMM_S = 4'd1,
        IMM_B = 4'd2,
        IMM_J = 4'd3,
        IMM_U = 4'd4
    } imm_src_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic     legal;
        logic     use_rs1;
        logic     use_rs2;
        logic     writes;
        logic     is_load;
        imm_src_t imm;
    } dec_t;

    // Classify an opcode. Unrecognised opcodes still read rs1 (they are only
    // excluded from writing the scoreboard) and select the I format.
    function automatic dec_t decode_op(input logic [6:0] op);
        dec_t d;
        d = '{legal: 1'b1, use_rs1: 1'b1, use_rs2: 1'b0, writes: 1'b1,
              is_load: 1'b0, imm: IMM_I};
        case (op)
            OP_LOAD:           d.is_load = 1'b1;
            OP_OPIMM, OP_JALR: d.imm     = IMM_I;
            OP_OP:             d.use_rs2 = 1'b1;
            OP_STORE: begin
                d.imm     = IMM_S;
                d.use_rs2 = 1'b1;
                d.writes  = 1'b0;
            end
            OP_BRANCH: begin
                d.imm     = IMM_B;
                d.use_rs2 = 1'b1;
                d.writes  = 1'b0;
            end
            OP_JAL: begin
                d.imm     = IMM_J;
                d.use_rs1 = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                d.imm     = IMM_U;
                d.use_rs1 = 1'b0;
            end
            default: begin
                d.legal  = 1'b0;
                d.writes = 1'b0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Fetch/decode/execute handshake bundle for the issue controller.
// slave = controller view, master = driver (fetch + execute) view.
interface decode_issue_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] instr_d;
    logic             valid_d;
    logic             ready_d;
    logic             flush_i;
    logic             ready_e;
    logic             issue_valid;
    logic [WIDTH-1:0] issue_instr;
    logic [3:0]       imm_src;
    logic             illegal_d;

    modport slave (
        input  instr_d, valid_d, flush_i, ready_e,
        output ready_d, issue_valid, issue_instr, imm_src, illegal_d
    );

    modport master (
        output instr_d, valid_d, flush_i, ready_e,
        input  ready_d, issue_valid, issue_instr, imm_src, illegal_d
    );
endinterface

// File: rtl/decode_issue_ctrl_scoreboard.sv
// Register scoreboard: one small down-counter per x1..x31 holding the number of
// execute advances left before that register's pending result is forwardable.
// x0 is never busy.
module decode_issue_ctrl_scoreboard
    import decode_issue_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_adv,
    input  logic             i_set,
    input  logic [4:0]       i_set_rd,
    input  logic [CNT_W-1:0] i_set_val,
    input  logic [4:0]       i_rs1,
    input  logic [4:0]       i_rs2,
    output logic             o_busy1,
    output logic             o_busy2
);

    logic [CNT_W-1:0] r_cnt [1:31];
    logic [31:0]      w_busy;

    // Load on issue (a new write overrides the old countdown), count down while execute advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (i_set && (i_set_rd == 5'(i))) begin
                    r_cnt[i] <= i_set_val;
                end else if (i_adv && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    // Flatten counters into a busy vector with x0 hard-wired idle
    always_comb begin
        w_busy = '0;
        for (int i = 1; i < 32; i++) begin
            w_busy[i] = (r_cnt[i] != '0);
        end
    end

    assign o_busy1 = w_busy[i_rs1];
    assign o_busy2 = w_busy[i_rs2];

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue controller: classifies the decode instruction, drives the
// immediate-format select, stalls on load-use hazards via the scoreboard and
// inserts bubbles after a redirect. Issue register gives 1-cycle latency to execute.
// Optional feature macro: ISSUE_CTRL_PERF_EN adds saturating stall_cnt/flush_cnt outputs.
module decode_issue_ctrl
    import decode_issue_ctrl_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int LOAD_LAT   = 2,
    parameter int ALU_LAT    = 0,
    parameter int FLUSH_BUBS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decode_issue_ctrl_if.slave   bus
`ifdef ISSUE_CTRL_PERF_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt
`endif
);

    localparam logic [CNT_W-1:0] LOAD_SET = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] ALU_SET  = CNT_W'(ALU_LAT);
    localparam logic [1:0]       BUB_INIT = 2'(FLUSH_BUBS - 1);

    dec_t             w_dec;
    logic [4:0]       w_rd;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic             w_busy1;
    logic             w_busy2;
    logic             w_hazard;
    logic             w_ready_d;
    logic             w_issue;
    logic             w_sb_set;

    issue_state_t     r_state;
    issue_state_t     w_state_nxt;
    logic [1:0]       r_bub;
    logic [1:0]       w_bub_nxt;

    logic             r_issue_valid;
    logic [WIDTH-1:0] r_issue_instr;

    assign w_dec = decode_op(bus.instr_d[6:0]);
    assign w_rd  = bus.instr_d[11:7];
    assign w_rs1 = bus.instr_d[19:15];
    assign w_rs2 = bus.instr_d[24:20];

    assign w_hazard = bus.valid_d & ((w_dec.use_rs1 & w_busy1) | (w_dec.use_rs2 & w_busy2));
    assign w_issue  = bus.valid_d & w_ready_d;
    assign w_sb_set = w_issue & w_dec.writes & (w_rd != 5'd0);

    decode_issue_ctrl_scoreboard u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_adv     (bus.ready_e),
        .i_set     (w_sb_set),
        .i_set_rd  (w_rd),
        .i_set_val (w_dec.is_load ? LOAD_SET : ALU_SET),
        .i_rs1     (w_rs1),
        .i_rs2     (w_rs2),
        .o_busy1   (w_busy1),
        .o_busy2   (w_busy2)
    );

    // FSM state and flush-bubble down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_bub   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bub   <= w_bub_nxt;
        end
    end

    // Next state and decode acceptance; a redirect always beats a hazard
    always_comb begin
        w_state_nxt = r_state;
        w_bub_nxt   = r_bub;
        w_ready_d   = 1'b0;
        case (r_state)
            ST_RUN, ST_STALL: begin
                w_ready_d = bus.ready_e & ~w_hazard & ~bus.flush_i;
                if (bus.flush_i) begin
                    w_state_nxt = ST_FLUSH;
                    w_bub_nxt   = BUB_INIT;
                end else if (w_hazard) begin
                    w_state_nxt = ST_STALL;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (bus.flush_i) begin
                    w_bub_nxt = BUB_INIT;
                end else if (r_bub == 2'd0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_bub_nxt = r_bub - 2'd1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_bub_nxt   = '0;
            end
        endcase
    end

    // Issue register toward execute; holds while execute is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_valid <= 1'b0;
            r_issue_instr <= '0;
        end else if (bus.ready_e) begin
            r_issue_valid <= w_issue;
            if (w_issue) begin
                r_issue_instr <= bus.instr_d;
            end
        end
    end

    assign bus.ready_d     = w_ready_d;
    assign bus.issue_valid = r_issue_valid;
    assign bus.issue_instr = r_issue_instr;
    assign bus.imm_src     = w_dec.imm;
    assign bus.illegal_d   = bus.valid_d & ~w_dec.legal;

`ifdef ISSUE_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Saturating occupancy counters for the STALL and FLUSH states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((r_state == ST_STALL) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if ((r_state == ST_FLUSH) && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Testbench for decode_issue_ctrl: table-driven vectors, hand sequences for
// stall/flush/reset corners, and randomized traffic against a reference model.
module tb_decode_issue_ctrl;

    localparam int WIDTH      = 32;
    localparam int LOAD_LAT   = 2;
    localparam int ALU_LAT    = 0;
    localparam int FLUSH_BUBS = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_issue_ctrl_if #(.WIDTH(WIDTH)) bus ();

`ifdef ISSUE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    decode_issue_ctrl #(
        .WIDTH(WIDTH), .LOAD_LAT(LOAD_LAT), .ALU_LAT(ALU_LAT), .FLUSH_BUBS(FLUSH_BUBS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ISSUE_CTRL_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a register is busy until the execute-advance count reaches free_at
    int unsigned adv_now;
    int unsigned free_at [32];
    int          bubbles_left;
    logic        m_iv;
    logic [31:0] m_ii;

    // Values sampled from the DUT in the most recent step
    logic        a_rdy, a_ill, a_iv;
    logic [3:0]  a_imm;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        adv_now = 0;
        for (int r = 0; r < 32; r++) free_at[r] = 0;
        bubbles_left = 0;
        m_iv = 1'b0;
        m_ii = '0;
    endtask

    function automatic bit reg_busy(input logic [4:0] r);
        return (r != 5'd0) && (adv_now < free_at[r]);
    endfunction

    function automatic void classify(input logic [31:0] ins, output bit legal, output bit u1,
                                     output bit u2, output bit wr, output int lat,
                                     output logic [3:0] imm);
        legal = 1; u1 = 1; u2 = 0; wr = 1; lat = ALU_LAT; imm = 4'd0;
        case (ins[6:0])
            7'b0000011: lat = LOAD_LAT;
            7'b0010011, 7'b1100111: ;
            7'b0110011: u2 = 1;
            7'b0100011: begin imm = 4'd1; u2 = 1; wr = 0; end
            7'b1100011: begin imm = 4'd2; u2 = 1; wr = 0; end
            7'b1101111: begin imm = 4'd3; u1 = 0; end
            7'b0110111, 7'b0010111: begin imm = 4'd4; u1 = 0; end
            default: begin legal = 0; wr = 0; end
        endcase
    endfunction

    // One clock cycle: called just after a rising edge; returns just after the next one
    task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic re);
        bit legal, u1, u2, wr, hazard, exp_rdy, issue;
        int lat;
        logic [3:0] exp_imm;
        bus.valid_d = v;
        bus.instr_d = ins;
        bus.flush_i = fl;
        bus.ready_e = re;
        classify(ins, legal, u1, u2, wr, lat, exp_imm);
        hazard  = v && ((u1 && reg_busy(ins[19:15])) || (u2 && reg_busy(ins[24:20])));
        exp_rdy = (bubbles_left == 0) && re && !hazard && !fl;
        @(negedge clk);
        a_rdy = bus.ready_d;
        a_imm = bus.imm_src;
        a_ill = bus.illegal_d;
        a_iv  = bus.issue_valid;
        check("ready_d", {31'd0, a_rdy}, {31'd0, exp_rdy});
        check("imm_src", {28'd0, a_imm}, {28'd0, exp_imm});
        check("illegal_d", {31'd0, a_ill}, {31'd0, v && !legal});
        check("issue_valid", {31'd0, a_iv}, {31'd0, m_iv});
        check("issue_instr", bus.issue_instr, m_ii);
        @(posedge clk);
        issue = exp_rdy && v;
        if (re) begin
            m_iv = issue;
            if (issue) m_ii = ins;
        end
        if (issue && wr && ins[11:7] != 5'd0) free_at[ins[11:7]] = adv_now + 1 + lat;
        if (re) adv_now++;
        if (fl) bubbles_left = FLUSH_BUBS;
        else if (bubbles_left > 0) bubbles_left--;
        #1;
    endtask

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic        exp_rdy;
        logic [3:0]  exp_imm;
        logic        exp_ill;
        logic        exp_iv;
    } vec_t;

    vec_t tbl [20];

    localparam logic [31:0] LW_X5    = 32'h0000A283;
    localparam logic [31:0] ADD_655  = 32'h00128333; // add x6,x5,x1
    localparam logic [31:0] ADDI_X5  = 32'h00100293;
    localparam logic [31:0] ADD_6X55 = 32'h00528333; // add x6,x5,x5
    localparam logic [31:0] LW_X0    = 32'h0000A003;
    localparam logic [31:0] ADD_100  = 32'h000000B3; // add x1,x0,x0
    localparam logic [31:0] LUI_X5   = 32'h000012B7;
    localparam logic [31:0] LW_X7    = 32'h0000A383;
    localparam logic [31:0] ADD_877  = 32'h00738433; // add x8,x7,x7

    logic [6:0] ops [10];
    logic [2:0] exp3;

    initial begin
        ops = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h13, 7'h33, 7'h7F};

        // imm_src sweep (all issue, no hazards)
        tbl[0]  = '{1, 32'h00500093, 1, 4'd0, 0, 0};
        tbl[1]  = '{1, 32'h00112023, 1, 4'd1, 0, 1};
        tbl[2]  = '{1, 32'h00000463, 1, 4'd2, 0, 1};
        tbl[3]  = '{1, 32'h0080006F, 1, 4'd3, 0, 1};
        tbl[4]  = '{1, 32'h000012B7, 1, 4'd4, 0, 1};
        tbl[5]  = '{1, 32'hFFFFFFFF, 1, 4'd0, 1, 1};
        // load-use: two stall cycles, dependant issues on the third
        tbl[6]  = '{1, LW_X5,   1, 4'd0, 0, 1};
        tbl[7]  = '{1, ADD_655, 0, 4'd0, 0, 1};
        tbl[8]  = '{1, ADD_655, 0, 4'd0, 0, 0};
        tbl[9]  = '{1, ADD_655, 1, 4'd0, 0, 0};
        tbl[10] = '{0, 32'h0,   1, 4'd0, 0, 1};
        // ALU result: back-to-back without stall
        tbl[11] = '{1, ADDI_X5,  1, 4'd0, 0, 0};
        tbl[12] = '{1, ADD_6X55, 1, 4'd0, 0, 1};
        tbl[13] = '{0, 32'h0,    1, 4'd0, 0, 1};
        // x0 never pending; U-type reads no sources and its write overrides the load
        tbl[14] = '{1, LW_X0,   1, 4'd0, 0, 0};
        tbl[15] = '{1, ADD_100, 1, 4'd0, 0, 1};
        tbl[16] = '{1, LW_X5,   1, 4'd0, 0, 1};
        tbl[17] = '{1, LUI_X5,  1, 4'd4, 0, 1};
        tbl[18] = '{1, ADD_655, 1, 4'd0, 0, 1};
        tbl[19] = '{0, 32'h0,   1, 4'd0, 0, 1};

        rst_n = 1'b0;
        bus.valid_d = 1'b0;
        bus.instr_d = '0;
        bus.flush_i = 1'b0;
        bus.ready_e = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset issue_valid", {31'd0, bus.issue_valid}, 32'd0);
        check("reset issue_instr", bus.issue_instr, 32'd0);
        check("reset ready_d", {31'd0, bus.ready_d}, 32'd1);
`ifdef ISSUE_CTRL_PERF_EN
        check("reset stall_cnt", stall_cnt, 32'd0);
        check("reset flush_cnt", flush_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].valid, tbl[i].instr, 1'b0, 1'b1);
            check($sformatf("tbl%0d ready_d", i), {31'd0, a_rdy}, {31'd0, tbl[i].exp_rdy});
            check($sformatf("tbl%0d imm_src", i), {28'd0, a_imm}, {28'd0, tbl[i].exp_imm});
            check($sformatf("tbl%0d illegal_d", i), {31'd0, a_ill}, {31'd0, tbl[i].exp_ill});
            check($sformatf("tbl%0d issue_valid", i), {31'd0, a_iv}, {31'd0, tbl[i].exp_iv});
        end
`ifdef ISSUE_CTRL_PERF_EN
        check("stall_cnt after load-use", stall_cnt, 32'd2);
`endif

        // ready_e low freezes the load countdown; stall lasts two cycles once it rises
        step(1, LW_X7, 0, 1);
        check("frz lw ready_d", {31'd0, a_rdy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1, ADD_877, 0, 0);
            check("frz hold ready_d", {31'd0, a_rdy}, 32'd0);
        end
        exp3 = 3'b100;
        for (int i = 0; i < 3; i++) begin
            step(1, ADD_877, 0, 1);
            check("frz resume ready_d", {31'd0, a_rdy}, {31'd0, exp3[i]});
        end

        // redirect while stalled: stalled instruction dropped, bubble, then run
        step(1, LW_X5, 0, 1);
        step(1, ADD_655, 0, 1);
        check("fl stall ready_d", {31'd0, a_rdy}, 32'd0);
        step(1, ADD_655, 1, 1);
        check("fl redirect ready_d", {31'd0, a_rdy}, 32'd0);
        step(1, ADD_655, 0, 1);
        check("fl bubble ready_d", {31'd0, a_rdy}, 32'd0);
        check("fl bubble issue_valid", {31'd0, a_iv}, 32'd0);
        step(1, ADDI_X5, 0, 1);
        check("fl resume ready_d", {31'd0, a_rdy}, 32'd1);
        check("fl resume issue_valid", {31'd0, a_iv}, 32'd0);
        step(0, 32'h0, 0, 1);
        check("fl after issue_valid", {31'd0, a_iv}, 32'd1);
`ifdef ISSUE_CTRL_PERF_EN
        check("flush_cnt after redirect", flush_cnt, 32'(FLUSH_BUBS));
`endif

        // asynchronous reset mid-operation clears everything at once
        step(1, LW_X5, 0, 1);
        rst_n = 1'b0;
        #1;
        check("async rst issue_valid", {31'd0, bus.issue_valid}, 32'd0);
        check("async rst issue_instr", bus.issue_instr, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        step(1, ADD_655, 0, 1);
        check("post rst ready_d", {31'd0, a_rdy}, 32'd1);
        step(0, 32'h0, 0, 1);
        check("post rst issue_valid", {31'd0, a_iv}, 32'd1);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins;
            logic [6:0]  op;
            ins = $urandom;
            op  = ($urandom_range(0, 19) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
            ins[6:0]   = op;
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            step(($urandom_range(0, 9) < 8), ins, ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 9) < 8));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
